// File: rtl/sid_pkg.sv
// Shared register layout, bus offsets and mixer state encoding for the SID register bank.
// Pure declarations; no latency or backpressure.
package sid_pkg;

   localparam int VOICE_STRIDE = 7;
   localparam int MAX_VOICES   = 8;

   localparam int REG_FREQ_LO = 0;
   localparam int REG_FREQ_HI = 1;
   localparam int REG_PW_LO   = 2;
   localparam int REG_PW_HI   = 3;
   localparam int REG_CTRL    = 4;
   localparam int REG_AD      = 5;
   localparam int REG_SR      = 6;

   localparam int FILT_FC_LO     = 0;
   localparam int FILT_FC_HI     = 1;
   localparam int FILT_RES_ROUTE = 2;
   localparam int FILT_MODE_VOL  = 3;
   localparam int FILT_POTX      = 4;
   localparam int FILT_POTY      = 5;
   localparam int FILT_OSC       = 6;
   localparam int FILT_ENV       = 7;
   localparam int FILT_ROUTE_X   = 8;

   typedef struct packed {
      logic [15:0] freq;
      logic [11:0] pw;
      logic [7:0]  ctrl;
      logic [7:0]  ad;
      logic [7:0]  sr;
   } voice_regs_t;

   // route is sized for the largest build; only the low NUM_VOICES bits are ever exported
   typedef struct packed {
      logic [10:0]           fc;
      logic [3:0]            res;
      logic [MAX_VOICES-1:0] route;
      logic                  ext;
      logic [3:0]            mode;
      logic [3:0]            vol;
   } filter_regs_t;

   typedef enum logic [1:0] {
      MIX_IDLE = 2'd0,
      MIX_ACC  = 2'd1,
      MIX_DONE = 2'd2
   } mix_state_t;

endpackage

// File: rtl/sid_mixer_seq.sv
// Time-multiplexed voice accumulator splitting voices into filtered and direct sums.
// Latency: mix_valid NUM_VOICES+1 cycles after clk_en; clk_en while busy is dropped and flagged.
module sid_mixer_seq
   import sid_pkg::*;
#(
   parameter int NUM_VOICES = 3,
   parameter int OFF_VOICE  = 2,
   localparam int SUM_W     = 12 + $clog2(NUM_VOICES + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clk_en,
   input  logic [12*NUM_VOICES-1:0] voice_out,
   input  logic [NUM_VOICES-1:0]   route,
   input  logic                    off3,
   output logic [SUM_W-1:0]        mix_filt,
   output logic [SUM_W-1:0]        mix_direct,
   output logic                    mix_valid,
   output logic                    mix_overrun
);

   localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_VOICES - 1);
   localparam bit OFF_EN = (OFF_VOICE < NUM_VOICES);

   mix_state_t       state;
   logic [IDX_W-1:0] idx;
   logic [SUM_W-1:0] acc_f;
   logic [SUM_W-1:0] acc_d;
   logic [11:0]      v_sel;
   logic             muted;

   always_comb begin
      v_sel = voice_out[32'(idx)*12 +: 12];
      muted = OFF_EN && off3 && (idx == IDX_W'(OFF_VOICE));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= MIX_IDLE;
         idx         <= '0;
         acc_f       <= '0;
         acc_d       <= '0;
         mix_filt    <= '0;
         mix_direct  <= '0;
         mix_valid   <= 1'b0;
         mix_overrun <= 1'b0;
      end else begin
         mix_valid   <= 1'b0;
         mix_overrun <= clk_en && (state != MIX_IDLE);
         case (state)
            MIX_IDLE: begin
               if (clk_en) begin
                  acc_f <= '0;
                  acc_d <= '0;
                  idx   <= '0;
                  state <= MIX_ACC;
               end
            end
            MIX_ACC: begin
               if (route[idx]) begin
                  acc_f <= acc_f + SUM_W'(v_sel);
               end else if (!muted) begin
                  acc_d <= acc_d + SUM_W'(v_sel);
               end
               if (idx == IDX_LAST) begin
                  idx   <= '0;
                  state <= MIX_DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            MIX_DONE: begin
               mix_filt   <= acc_f;
               mix_direct <= acc_d;
               mix_valid  <= 1'b1;
               state      <= MIX_IDLE;
            end
            default: state <= MIX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/sid_regbank.sv
// SID register bank: CPU decode, registered readback, bus-latch decay and voice mixer.
// Latency: writes land on the sampling edge, reads return one cycle later; no backpressure.
module sid_regbank
   import sid_pkg::*;
#(
   parameter int NUM_VOICES  = 3,
   parameter int ADDR_W      = 5,
   parameter int READ_VOICE  = 2,
   parameter int OFF_VOICE   = 2,
   parameter int DECAY_TICKS = 8192,
   localparam int SUM_W      = 12 + $clog2(NUM_VOICES + 1)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clk_en,
   input  logic [ADDR_W-1:0]        addr,
   input  logic [7:0]               data_in,
   output logic [7:0]               data_out,
   output logic                     data_oe,
   input  logic                     n_cs,
   input  logic                     rw,
   output logic [16*NUM_VOICES-1:0] v_freq,
   output logic [12*NUM_VOICES-1:0] v_pw,
   output logic [8*NUM_VOICES-1:0]  v_ctrl,
   output logic [8*NUM_VOICES-1:0]  v_ad,
   output logic [8*NUM_VOICES-1:0]  v_sr,
   output logic [10:0]              f_fc,
   output logic [3:0]               f_res,
   output logic [3:0]               f_mode,
   output logic [3:0]               f_vol,
   output logic [NUM_VOICES:0]      f_route,
   input  logic [12*NUM_VOICES-1:0] voice_out,
   input  logic [8*NUM_VOICES-1:0]  osc_in,
   input  logic [8*NUM_VOICES-1:0]  env_in,
   input  logic [7:0]               pot_x,
   input  logic [7:0]               pot_y,
   output logic [SUM_W-1:0]         mix_filt,
   output logic [SUM_W-1:0]         mix_direct,
   output logic                     mix_valid,
   output logic                     mix_overrun
);

   localparam int FILT_BASE = VOICE_STRIDE * NUM_VOICES;
   localparam int DCNT_W    = $clog2(DECAY_TICKS + 1);
   localparam logic [DCNT_W-1:0] DECAY_TERM = DCNT_W'(DECAY_TICKS);
   localparam logic [DCNT_W-1:0] DECAY_LAST = DCNT_W'(DECAY_TICKS - 1);

   voice_regs_t       vregs [NUM_VOICES];
   filter_regs_t      fregs;
   logic [7:0]        bus_latch;
   logic [DCNT_W-1:0] decay_cnt;
   logic [7:0]        rd_dat;
   logic              acc_vld;
   logic              wr_vld;
   logic              rd_vld;
   int                a;

   always_comb begin
      acc_vld = !n_cs;
      wr_vld  = acc_vld && !rw;
      rd_vld  = acc_vld && rw;
      a       = 32'(addr);
   end

   // Only the four live inputs read back; everything else returns the decaying bus latch
   always_comb begin
      rd_dat = bus_latch;
      if (a == FILT_BASE + FILT_POTX) rd_dat = pot_x;
      if (a == FILT_BASE + FILT_POTY) rd_dat = pot_y;
      if (a == FILT_BASE + FILT_OSC)  rd_dat = osc_in[READ_VOICE*8 +: 8];
      if (a == FILT_BASE + FILT_ENV)  rd_dat = env_in[READ_VOICE*8 +: 8];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_VOICES; i++) vregs[i] <= '0;
         fregs <= '0;
      end else if (wr_vld) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            if (a == VOICE_STRIDE*i + REG_FREQ_LO) vregs[i].freq[7:0]  <= data_in;
            if (a == VOICE_STRIDE*i + REG_FREQ_HI) vregs[i].freq[15:8] <= data_in;
            if (a == VOICE_STRIDE*i + REG_PW_LO)   vregs[i].pw[7:0]    <= data_in;
            if (a == VOICE_STRIDE*i + REG_PW_HI)   vregs[i].pw[11:8]   <= data_in[3:0];
            if (a == VOICE_STRIDE*i + REG_CTRL)    vregs[i].ctrl       <= data_in;
            if (a == VOICE_STRIDE*i + REG_AD)      vregs[i].ad         <= data_in;
            if (a == VOICE_STRIDE*i + REG_SR)      vregs[i].sr         <= data_in;
         end
         if (a == FILT_BASE + FILT_FC_LO) fregs.fc[2:0]  <= data_in[2:0];
         if (a == FILT_BASE + FILT_FC_HI) fregs.fc[10:3] <= data_in;
         if (a == FILT_BASE + FILT_RES_ROUTE) begin
            fregs.res        <= data_in[7:4];
            fregs.route[2:0] <= data_in[3:1];
            fregs.ext        <= data_in[0];
         end
         if (a == FILT_BASE + FILT_MODE_VOL) begin
            fregs.mode <= data_in[7:4];
            fregs.vol  <= data_in[3:0];
         end
         if (NUM_VOICES > 3 && a == FILT_BASE + FILT_ROUTE_X)
            fregs.route[MAX_VOICES-1:3] <= data_in[MAX_VOICES-4:0];
      end
   end

   // A write or read in the same cycle as the terminal tick restarts the count and keeps the latch
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out  <= '0;
         data_oe   <= 1'b0;
         bus_latch <= '0;
         decay_cnt <= '0;
      end else begin
         data_oe <= rd_vld;
         if (rd_vld) begin
            data_out  <= rd_dat;
            bus_latch <= rd_dat;
         end
         if (wr_vld) bus_latch <= data_in;
         if (acc_vld) begin
            decay_cnt <= '0;
         end else if (clk_en && decay_cnt != DECAY_TERM) begin
            decay_cnt <= decay_cnt + 1'b1;
            if (decay_cnt == DECAY_LAST) bus_latch <= '0;
         end
      end
   end

   for (genvar i = 0; i < NUM_VOICES; i++) begin : g_vout
      assign v_freq[i*16 +: 16] = vregs[i].freq;
      assign v_pw[i*12 +: 12]   = vregs[i].pw;
      assign v_ctrl[i*8 +: 8]   = vregs[i].ctrl;
      assign v_ad[i*8 +: 8]     = vregs[i].ad;
      assign v_sr[i*8 +: 8]     = vregs[i].sr;
   end

   assign f_fc    = fregs.fc;
   assign f_res   = fregs.res;
   assign f_mode  = fregs.mode;
   assign f_vol   = fregs.vol;
   assign f_route = {fregs.ext, fregs.route[NUM_VOICES-1:0]};

   sid_mixer_seq #(
      .NUM_VOICES (NUM_VOICES),
      .OFF_VOICE  (OFF_VOICE)
   ) u_mixer (
      .clk         (clk),
      .reset       (reset),
      .clk_en      (clk_en),
      .voice_out   (voice_out),
      .route       (fregs.route[NUM_VOICES-1:0]),
      .off3        (fregs.mode[3]),
      .mix_filt    (mix_filt),
      .mix_direct  (mix_direct),
      .mix_valid   (mix_valid),
      .mix_overrun (mix_overrun)
   );

endmodule

// File: tb/tb_sid_regbank.sv
// Directed bench for sid_regbank: a 3-voice and a 5-voice instance with short decay.
module tb_sid_regbank;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        clk_en = 1'b0;
   logic [7:0]  data_in = '0;
   logic        rw = 1'b0;
   logic [7:0]  pot_x = 8'hC3;
   logic [7:0]  pot_y = 8'h5E;

   // 3-voice instance
   logic [4:0]  addr3 = '0;
   logic        n_cs3 = 1'b1;
   logic [7:0]  data_out3;
   logic        data_oe3;
   logic [47:0] v_freq3;
   logic [35:0] v_pw3;
   logic [23:0] v_ctrl3, v_ad3, v_sr3;
   logic [10:0] f_fc3;
   logic [3:0]  f_res3, f_mode3, f_vol3;
   logic [3:0]  f_route3;
   logic [35:0] voice_out3 = {12'hFFF, 12'h800, 12'h001};
   logic [23:0] osc_in3 = {8'hA5, 8'h11, 8'h22};
   logic [23:0] env_in3 = {8'h3C, 8'h44, 8'h55};
   logic [13:0] mix_filt3, mix_direct3;
   logic        mix_valid3, mix_overrun3;

   // 5-voice instance
   logic [5:0]  addr5 = '0;
   logic        n_cs5 = 1'b1;
   logic [7:0]  data_out5;
   logic        data_oe5;
   logic [79:0] v_freq5;
   logic [59:0] v_pw5;
   logic [39:0] v_ctrl5, v_ad5, v_sr5;
   logic [10:0] f_fc5;
   logic [3:0]  f_res5, f_mode5, f_vol5;
   logic [5:0]  f_route5;
   logic [59:0] voice_out5 = {12'h010, 12'h008, 12'h004, 12'h002, 12'h001};
   logic [39:0] osc_in5 = '0;
   logic [39:0] env_in5 = '0;
   logic [14:0] mix_filt5, mix_direct5;
   logic        mix_valid5, mix_overrun5;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   sid_regbank #(.NUM_VOICES(3), .ADDR_W(5), .READ_VOICE(2), .OFF_VOICE(2), .DECAY_TICKS(16)) u3 (
      .clk(clk), .reset(reset), .clk_en(clk_en), .addr(addr3), .data_in(data_in),
      .data_out(data_out3), .data_oe(data_oe3), .n_cs(n_cs3), .rw(rw),
      .v_freq(v_freq3), .v_pw(v_pw3), .v_ctrl(v_ctrl3), .v_ad(v_ad3), .v_sr(v_sr3),
      .f_fc(f_fc3), .f_res(f_res3), .f_mode(f_mode3), .f_vol(f_vol3), .f_route(f_route3),
      .voice_out(voice_out3), .osc_in(osc_in3), .env_in(env_in3), .pot_x(pot_x), .pot_y(pot_y),
      .mix_filt(mix_filt3), .mix_direct(mix_direct3), .mix_valid(mix_valid3), .mix_overrun(mix_overrun3)
   );

   sid_regbank #(.NUM_VOICES(5), .ADDR_W(6), .READ_VOICE(2), .OFF_VOICE(2), .DECAY_TICKS(16)) u5 (
      .clk(clk), .reset(reset), .clk_en(clk_en), .addr(addr5), .data_in(data_in),
      .data_out(data_out5), .data_oe(data_oe5), .n_cs(n_cs5), .rw(rw),
      .v_freq(v_freq5), .v_pw(v_pw5), .v_ctrl(v_ctrl5), .v_ad(v_ad5), .v_sr(v_sr5),
      .f_fc(f_fc5), .f_res(f_res5), .f_mode(f_mode5), .f_vol(f_vol5), .f_route(f_route5),
      .voice_out(voice_out5), .osc_in(osc_in5), .env_in(env_in5), .pot_x(pot_x), .pot_y(pot_y),
      .mix_filt(mix_filt5), .mix_direct(mix_direct5), .mix_valid(mix_valid5), .mix_overrun(mix_overrun5)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bus_wr(input int inst, input int ad, input logic [7:0] d);
      @(negedge clk);
      rw = 1'b0;
      data_in = d;
      if (inst == 5) begin
         addr5 = 6'(ad);
         n_cs5 = 1'b0;
      end else begin
         addr3 = 5'(ad);
         n_cs3 = 1'b0;
      end
      @(negedge clk);
      n_cs3 = 1'b1;
      n_cs5 = 1'b1;
   endtask

   // returns on the negedge after the sampling edge, where data_out/data_oe are valid
   task automatic bus_rd3(input int ad);
      @(negedge clk);
      rw = 1'b1;
      addr3 = 5'(ad);
      n_cs3 = 1'b0;
      @(negedge clk);
      n_cs3 = 1'b1;
      rw = 1'b0;
   endtask

   task automatic tick();
      @(negedge clk);
      clk_en = 1'b1;
      @(negedge clk);
      clk_en = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_data_out", 32'(data_out3), 32'h0);
      check("rst_data_oe", 32'(data_oe3), 32'h0);
      check("rst_v_freq", v_freq3[31:0], 32'h0);
      check("rst_f_route", 32'(f_route3), 32'h0);
      check("rst_mix_filt", 32'(mix_filt3), 32'h0);
      check("rst_mix_valid", 32'(mix_valid3), 32'h0);
      reset = 1'b0;

      // freq write; hi first so the latch ends on the low byte
      bus_wr(3, 1, 8'h12);
      bus_wr(3, 0, 8'h34);
      check("freq0", 32'(v_freq3[15:0]), 32'h1234);
      bus_rd3(0);
      check("rd_wo_latch", 32'(data_out3), 32'h34);
      check("rd_oe_hi", 32'(data_oe3), 32'h1);
      @(negedge clk);
      check("rd_oe_lo", 32'(data_oe3), 32'h0);

      bus_wr(3, 2, 8'hCD);
      bus_wr(3, 3, 8'hFB);
      check("pw0", 32'(v_pw3[11:0]), 32'hBCD);
      bus_wr(3, 11, 8'h41);
      check("ctrl1", 32'(v_ctrl3[15:8]), 32'h41);
      bus_wr(3, 19, 8'h9A);
      check("ad2", 32'(v_ad3[23:16]), 32'h9A);
      bus_wr(3, 20, 8'h3E);
      check("sr2", 32'(v_sr3[23:16]), 32'h3E);

      bus_wr(3, 21, 8'h05);
      bus_wr(3, 22, 8'hAB);
      check("fc", 32'(f_fc3), 32'h55D);
      bus_wr(3, 23, 8'h75);
      check("res", 32'(f_res3), 32'h7);
      check("route", 32'(f_route3), 32'hA);
      bus_wr(3, 24, 8'h8F);
      check("mode", 32'(f_mode3), 32'h8);
      check("vol", 32'(f_vol3), 32'hF);

      bus_rd3(27);
      check("rd_osc", 32'(data_out3), 32'hA5);
      bus_rd3(28);
      check("rd_env", 32'(data_out3), 32'h3C);
      bus_rd3(2);
      check("rd_latch_from_read", 32'(data_out3), 32'h3C);
      bus_rd3(25);
      check("rd_potx", 32'(data_out3), 32'hC3);
      bus_rd3(26);
      check("rd_poty", 32'(data_out3), 32'h5E);

      // writes to read-only and unmapped addresses only touch the latch
      bus_wr(3, 25, 8'hEE);
      check("ro_wr_fc", 32'(f_fc3), 32'h55D);
      check("ro_wr_mode", 32'(f_mode3), 32'h8);
      bus_rd3(0);
      check("ro_wr_latch", 32'(data_out3), 32'hEE);
      bus_wr(3, 29, 8'hFF);
      check("unmapped_route", 32'(f_route3), 32'hA);
      check("unmapped_res", 32'(f_res3), 32'h7);
      check("unmapped_freq", 32'(v_freq3[15:0]), 32'h1234);

      // one frame: valid exactly 4 cycles after the sampled clk_en
      repeat (8) @(negedge clk);
      clk_en = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         clk_en = 1'b0;
         check($sformatf("valid_k%0d", k), 32'(mix_valid3), 32'(k == 4));
      end
      check("mix_filt", 32'(mix_filt3), 32'h800);
      check("mix_direct", 32'(mix_direct3), 32'h001);

      // second clk_en one cycle into the frame
      repeat (8) @(negedge clk);
      clk_en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (k == 1) clk_en = 1'b0;
         check($sformatf("ovr_k%0d", k), 32'(mix_overrun3), 32'(k == 1));
         check($sformatf("ovr_valid_k%0d", k), 32'(mix_valid3), 32'(k == 4));
      end

      // 5 voices: extended route register gates voices 3 and 4
      bus_wr(5, 43, 8'h02);
      check("route5", 32'(f_route5), 32'h10);
      repeat (8) @(negedge clk);
      clk_en = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         clk_en = 1'b0;
         check($sformatf("valid5_k%0d", k), 32'(mix_valid5), 32'(k == 6));
      end
      check("mix_filt5", 32'(mix_filt5), 32'h010);
      check("mix_direct5", 32'(mix_direct5), 32'h00F);

      // bus latch decay
      bus_wr(3, 4, 8'h5A);
      repeat (15) tick();
      bus_rd3(4);
      check("decay_hold", 32'(data_out3), 32'h5A);
      bus_wr(3, 4, 8'h77);
      repeat (16) tick();
      bus_rd3(4);
      check("decay_clear", 32'(data_out3), 32'h00);
      bus_wr(3, 4, 8'h66);
      repeat (15) tick();
      @(negedge clk);
      clk_en = 1'b1;
      rw = 1'b0;
      data_in = 8'h99;
      addr3 = 5'd4;
      n_cs3 = 1'b0;
      @(negedge clk);
      clk_en = 1'b0;
      n_cs3 = 1'b1;
      repeat (8) @(negedge clk);
      bus_rd3(4);
      check("decay_access_wins", 32'(data_out3), 32'h99);

      // reset in the middle of accumulation
      repeat (8) @(negedge clk);
      clk_en = 1'b1;
      @(negedge clk);
      clk_en = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("midrst_filt", 32'(mix_filt3), 32'h0);
      check("midrst_direct", 32'(mix_direct3), 32'h0);
      check("midrst_freq", 32'(v_freq3[15:0]), 32'h0);
      check("midrst_data_out", 32'(data_out3), 32'h0);
      check("midrst_route", 32'(f_route3), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check($sformatf("midrst_novalid_k%0d", k), 32'(mix_valid3), 32'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
